// File: rtl/valid_dirty_array_pkg.sv
// Shared types for the valid/dirty line-state store: write command encoding,
// flush sequencer states and the way-select width helper.
package valid_dirty_array_pkg;

    typedef enum logic [1:0] {
        WCMD_SET_CLEAN = 2'b00,
        WCMD_SET_DIRTY = 2'b01,
        WCMD_CLR_DIRTY = 2'b10,
        WCMD_INV       = 2'b11
    } wcmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WALK = 2'b01,
        DONE = 2'b10
    } flush_state_e;

    // A direct-mapped cache still needs a one-bit way field.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/valid_dirty_array_if.sv
// Access/flush bundle between a cache controller (master) and the valid/dirty
// store (slave), plus the store's flush-sequencer state for observation.
interface valid_dirty_array_if
    import valid_dirty_array_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = way_w(WAYS)
);
    // Handshake: there is no ready signal. An access (CS=1) is taken at the
    // clock edge only while the sequencer is IDLE and flush is low; at any
    // other time it is silently dropped, and busy/flush_done tell the master
    // when that is the case.
    logic             CS;
    logic             OE;
    logic [IDX_W-1:0] A;
    logic [WAY_W-1:0] WAY;
    logic [1:0]       WCMD;
    logic             flush;
    logic [WAYS-1:0]  v_bits;
    logic [WAYS-1:0]  d_bits;
    logic             busy;
    logic             flush_done;
    flush_state_e     state_dbg;

    modport master (
        output CS, OE, A, WAY, WCMD, flush,
        input  v_bits, d_bits, busy, flush_done, state_dbg
    );

    modport slave (
        input  CS, OE, A, WAY, WCMD, flush,
        output v_bits, d_bits, busy, flush_done, state_dbg
    );

endinterface

// File: rtl/valid_dirty_array.sv
// SETS x WAYS valid/dirty bit store with registered per-set reads, per-line
// write commands and a one-set-per-cycle flush-all sequencer.
module valid_dirty_array
    import valid_dirty_array_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = way_w(WAYS)
) (
    input  logic              CK,
    input  logic              rst,
    valid_dirty_array_if.slave bus
);

    flush_state_e     state_q;
    flush_state_e     state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [WAYS-1:0]  v_mem [SETS];
    logic [WAYS-1:0]  d_mem [SETS];
    logic [WAYS-1:0]  v_bits_q;
    logic [WAYS-1:0]  d_bits_q;
    logic [WAYS-1:0]  way_mask;
    logic [WAYS-1:0]  v_wr;
    logic [WAYS-1:0]  d_wr;
    logic             access;
    logic             rd_en;
    logic             wr_en;
    logic             last_set;
    wcmd_e            wcmd;

    // A flush request in the same cycle wins over the access.
    assign access   = (state_q == IDLE) && bus.CS && !bus.flush;
    assign rd_en    = access && bus.OE;
    assign wr_en    = access && !bus.OE;
    assign last_set = (cnt_q == IDX_W'(SETS - 1));
    assign way_mask = WAYS'(1) << bus.WAY;
    assign wcmd     = wcmd_e'(bus.WCMD);

    // New contents of set A after applying the write command to one way.
    always_comb begin
        v_wr = v_mem[bus.A];
        d_wr = d_mem[bus.A];
        case (wcmd)
            WCMD_SET_CLEAN: begin
                v_wr = v_wr | way_mask;
                d_wr = d_wr & ~way_mask;
            end
            WCMD_SET_DIRTY: begin
                v_wr = v_wr | way_mask;
                d_wr = d_wr | way_mask;
            end
            WCMD_CLR_DIRTY: begin
                d_wr = d_wr & ~way_mask;
            end
            default: begin
                v_wr = v_wr & ~way_mask;
                d_wr = d_wr & ~way_mask;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.flush) state_d = WALK;
            WALK:    if (last_set) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state_q == WALK);
        bus.flush_done = (state_q == DONE);
        bus.state_dbg  = state_q;
    end

    // The walk stops at the last set; the counter never wraps.
    always_ff @(posedge CK) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) && bus.flush) begin
            cnt_q <= '0;
        end else if ((state_q == WALK) && !last_set) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flop storage so reset can clear every line in a single edge.
    always_ff @(posedge CK) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                v_mem[s] <= '0;
                d_mem[s] <= '0;
            end
        end else if (state_q == WALK) begin
            v_mem[cnt_q] <= '0;
            d_mem[cnt_q] <= '0;
        end else if (wr_en) begin
            v_mem[bus.A] <= v_wr;
            d_mem[bus.A] <= d_wr;
        end
    end

    always_ff @(posedge CK) begin
        if (rst) begin
            v_bits_q <= '0;
            d_bits_q <= '0;
        end else if (rd_en) begin
            v_bits_q <= v_mem[bus.A];
            d_bits_q <= d_mem[bus.A];
        end
    end

    assign bus.v_bits = v_bits_q;
    assign bus.d_bits = d_bits_q;

endmodule

// File: tb/tb_valid_dirty_array.sv
// Directed bench for valid_dirty_array (SETS=64, WAYS=2): a table of single-cycle
// accesses plus hand-written flush, overlap and reset-during-flush sequences.
module tb_valid_dirty_array;
    import valid_dirty_array_pkg::*;

    localparam int SETS = 64;
    localparam int WAYS = 2;

    logic CK;
    logic rst;
    int   tests;
    int   fails;
    logic [3:0] exp_q[$];

    valid_dirty_array_if #(.SETS(SETS), .WAYS(WAYS)) bus ();

    valid_dirty_array #(.SETS(SETS), .WAYS(WAYS)) dut (
        .CK  (CK),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       cs;
        logic       oe;
        logic [5:0] a;
        logic       way;
        logic [1:0] wcmd;
        logic [1:0] exp_v;
        logic [1:0] exp_d;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.CS    = 1'b0;
        bus.OE    = 1'b0;
        bus.A     = '0;
        bus.WAY   = '0;
        bus.WCMD  = 2'b00;
        bus.flush = 1'b0;
    endtask

    // Drive one cycle of inputs from the falling edge, leave #1 after the
    // rising edge with inputs released.
    task automatic do_access(input logic cs, input logic oe, input int a, input logic way,
                             input logic [1:0] wcmd, input logic fl);
        @(negedge CK);
        bus.CS    = cs;
        bus.OE    = oe;
        bus.A     = 6'(a);
        bus.WAY   = way;
        bus.WCMD  = wcmd;
        bus.flush = fl;
        @(posedge CK);
        #1;
        idle_inputs();
    endtask

    task automatic read_check(input string name, input int a, input logic [1:0] ev, input logic [1:0] ed);
        do_access(1'b1, 1'b1, a, 1'b0, 2'b00, 1'b0);
        check({name, "_v"}, 32'(bus.v_bits), 32'(ev));
        check({name, "_d"}, 32'(bus.d_bits), 32'(ed));
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Entered #1 into cycle t+1 after the flush was accepted; k counts cycles from t.
    task automatic track_flush(input bit inject, output int busy_cycles, output int done_k);
        busy_cycles = 0;
        done_k      = 0;
        for (int k = 1; k <= 200 && done_k == 0; k++) begin
            if (bus.busy) busy_cycles++;
            if (bus.flush_done) begin
                done_k = k;
                check("busy_low_in_done_cycle", 32'(bus.busy), 32'd0);
                if (inject) begin
                    bus.CS = 1'b1; bus.OE = 1'b0; bus.A = 6'd4; bus.WAY = 1'b0; bus.WCMD = 2'b00;
                end
            end
            if (inject && k == 10) begin
                bus.CS = 1'b1; bus.OE = 1'b0; bus.A = 6'd3; bus.WAY = 1'b0; bus.WCMD = 2'b00;
                bus.flush = 1'b1;
            end
            tick();
            idle_inputs();
        end
    endtask

    initial begin
        int busy_cycles;
        int done_k;
        int pulses;
        logic [3:0] exp;
        tests = 0;
        fails = 0;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge CK);
        #1;
        rst = 1'b0;

        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_flush_done", 32'(bus.flush_done), 32'd0);
        check("reset_v_bits", 32'(bus.v_bits), 32'd0);
        check("reset_state_idle", 32'(bus.state_dbg), 32'(IDLE));
        for (int s = 0; s < SETS; s++) begin
            read_check($sformatf("reset_read_set%0d", s), s, 2'b00, 2'b00);
            check($sformatf("reset_busy_set%0d", s), 32'(bus.busy), 32'd0);
        end

        // cs oe a way wcmd -> v_bits d_bits after the edge
        vecs[0]  = '{1'b1, 1'b1, 6'd5,  1'b0, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 1'b0, 6'd5,  1'b1, 2'b01, 2'b00, 2'b00};
        vecs[2]  = '{1'b1, 1'b1, 6'd5,  1'b0, 2'b00, 2'b10, 2'b10};
        vecs[3]  = '{1'b1, 1'b0, 6'd5,  1'b1, 2'b10, 2'b10, 2'b10};
        vecs[4]  = '{1'b1, 1'b1, 6'd5,  1'b0, 2'b00, 2'b10, 2'b00};
        vecs[5]  = '{1'b1, 1'b0, 6'd5,  1'b1, 2'b11, 2'b10, 2'b00};
        vecs[6]  = '{1'b1, 1'b1, 6'd5,  1'b0, 2'b00, 2'b00, 2'b00};
        vecs[7]  = '{1'b1, 1'b0, 6'd5,  1'b0, 2'b10, 2'b00, 2'b00};
        vecs[8]  = '{1'b1, 1'b1, 6'd5,  1'b0, 2'b00, 2'b00, 2'b00};
        vecs[9]  = '{1'b1, 1'b0, 6'd6,  1'b0, 2'b00, 2'b00, 2'b00};
        vecs[10] = '{1'b1, 1'b0, 6'd6,  1'b1, 2'b01, 2'b00, 2'b00};
        vecs[11] = '{1'b1, 1'b1, 6'd6,  1'b0, 2'b00, 2'b11, 2'b10};
        vecs[12] = '{1'b1, 1'b1, 6'd63, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{1'b1, 1'b0, 6'd63, 1'b1, 2'b01, 2'b00, 2'b00};
        vecs[14] = '{1'b1, 1'b1, 6'd63, 1'b0, 2'b00, 2'b10, 2'b10};
        vecs[15] = '{1'b1, 1'b1, 6'd0,  1'b0, 2'b00, 2'b00, 2'b00};
        vecs[16] = '{1'b0, 1'b1, 6'd63, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[17] = '{1'b0, 1'b0, 6'd0,  1'b0, 2'b01, 2'b00, 2'b00};
        vecs[18] = '{1'b1, 1'b1, 6'd0,  1'b0, 2'b00, 2'b00, 2'b00};

        for (int i = 0; i < 19; i++) begin
            exp_q.push_back({vecs[i].exp_v, vecs[i].exp_d});
            do_access(vecs[i].cs, vecs[i].oe, int'(vecs[i].a), vecs[i].way, vecs[i].wcmd, 1'b0);
            exp = exp_q.pop_front();
            check($sformatf("vec%0d_v", i), 32'(bus.v_bits), 32'(exp[3:2]));
            check($sformatf("vec%0d_d", i), 32'(bus.d_bits), 32'(exp[1:0]));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
        end

        // Fill every line dirty, then flush all.
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                do_access(1'b1, 1'b0, s, w[0], 2'b01, 1'b0);
            end
        end
        read_check("fill_set0", 0, 2'b11, 2'b11);
        read_check("fill_set63", 63, 2'b11, 2'b11);
        do_access(1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b1);
        check("flush1_state_walk", 32'(bus.state_dbg), 32'(WALK));
        track_flush(1'b0, busy_cycles, done_k);
        check("flush1_busy_cycles", 32'(busy_cycles), 32'd64);
        check("flush1_done_cycle", 32'(done_k), 32'd65);
        check("flush1_done_pulse_width", 32'(bus.flush_done), 32'd0);
        for (int s = 0; s < SETS; s++) begin
            do_access(1'b1, 1'b1, s, 1'b0, 2'b00, 1'b0);
            check($sformatf("flush1_read_set%0d", s), 32'({bus.v_bits, bus.d_bits}), 32'd0);
        end

        // Access and second flush during a walk, access during flush_done.
        do_access(1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b1);
        track_flush(1'b1, busy_cycles, done_k);
        check("flush2_busy_cycles", 32'(busy_cycles), 32'd64);
        check("flush2_done_cycle", 32'(done_k), 32'd65);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.busy || bus.flush_done) pulses++;
            tick();
        end
        check("flush2_no_second_walk", 32'(pulses), 32'd0);
        read_check("flush2_set3", 3, 2'b00, 2'b00);
        read_check("flush2_set4", 4, 2'b00, 2'b00);

        // Flush and write in the same IDLE cycle: flush wins.
        do_access(1'b1, 1'b0, 7, 1'b0, 2'b00, 1'b1);
        check("flush3_busy_started", 32'(bus.busy), 32'd1);
        track_flush(1'b0, busy_cycles, done_k);
        check("flush3_busy_cycles", 32'(busy_cycles), 32'd64);
        read_check("flush3_set7", 7, 2'b00, 2'b00);

        // Reset in cycle t+20 of a walk.
        do_access(1'b1, 1'b0, 50, 1'b1, 2'b01, 1'b0);
        read_check("rstflush_pre_set50", 50, 2'b10, 2'b10);
        do_access(1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b1);
        repeat (19) tick();
        check("rstflush_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstflush_busy", 32'(bus.busy), 32'd0);
        check("rstflush_flush_done", 32'(bus.flush_done), 32'd0);
        check("rstflush_v_bits", 32'(bus.v_bits), 32'd0);
        check("rstflush_d_bits", 32'(bus.d_bits), 32'd0);
        do_access(1'b1, 1'b0, 2, 1'b1, 2'b01, 1'b0);
        read_check("rstflush_write_set2", 2, 2'b10, 2'b10);
        read_check("rstflush_set50", 50, 2'b00, 2'b00);
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            if (bus.busy || bus.flush_done) pulses++;
            tick();
        end
        check("rstflush_no_done_pulse", 32'(pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
